// File: rtl/alu181_slice_sequencer.sv
// Sequencer that time-multiplexes one 4-bit 74181 slice into a W-bit ALU, LSB nibble first.
// Optional ALU181_ZERO_EN adds a registered rsp_zero flag alongside the response.
module alu181_slice_sequencer #(
  parameter int SLICES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4*SLICES-1:0]   req_a,
  input  logic [4*SLICES-1:0]   req_b,
  input  logic [3:0]            req_s,
  input  logic                  req_m,
  input  logic                  req_cnb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [4*SLICES-1:0]   rsp_f,
  output logic                  rsp_cn4b,
  output logic                  rsp_aeb,
`ifdef ALU181_ZERO_EN
  output logic                  rsp_zero,
`endif
  output logic [3:0]            alu_a,
  output logic [3:0]            alu_b,
  output logic [3:0]            alu_s,
  output logic                  alu_m,
  output logic                  alu_cnb,
  input  logic [3:0]            alu_f,
  input  logic                  alu_cn4b,
  input  logic                  alu_aeb,
  output logic [1:0]            dbg_state
);

  localparam int W  = 4 * SLICES;
  localparam int KW = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [KW-1:0]  k;
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic [W-1:0]   res_sh;
  logic [W-1:0]   res_next;
  logic [3:0]     s_q;
  logic           m_q;
  logic           carry_q;
  logic           aeb_q;
  logic           last_slice;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the sender holds valid and payload stable until that edge, ready never depends on valid.

  // Operand shift registers feed the ALU straight from flops; the slice result enters at the top
  // so that after SLICES shifts nibble 0 has arrived at the bottom.
  assign alu_a      = a_sh[3:0];
  assign alu_b      = b_sh[3:0];
  assign alu_s      = s_q;
  assign alu_m      = m_q;
  assign alu_cnb    = carry_q;
  assign dbg_state  = state;
  assign last_slice = (k == KW'(SLICES - 1));

  always_comb begin
    res_next = (res_sh >> 4) | (W'(alu_f) << (W - 4));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_f     <= '0;
      rsp_cn4b  <= 1'b1;
      rsp_aeb   <= 1'b0;
`ifdef ALU181_ZERO_EN
      rsp_zero  <= 1'b0;
`endif
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      s_q       <= 4'd0;
      m_q       <= 1'b0;
      carry_q   <= 1'b1;
      aeb_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_sh      <= req_a;
            b_sh      <= req_b;
            s_q       <= req_s;
            m_q       <= req_m;
            carry_q   <= req_cnb;
            aeb_q     <= 1'b1;
            k         <= '0;
            req_ready <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          res_sh  <= res_next;
          carry_q <= alu_cn4b;
          aeb_q   <= aeb_q & alu_aeb;
          a_sh    <= a_sh >> 4;
          b_sh    <= b_sh >> 4;
          if (last_slice) begin
            // Response fields are loaded once here so they stay frozen through DONE and beyond.
            k         <= '0;
            rsp_valid <= 1'b1;
            rsp_f     <= res_next;
            rsp_cn4b  <= alu_cn4b;
            rsp_aeb   <= aeb_q & alu_aeb;
`ifdef ALU181_ZERO_EN
            rsp_zero  <= (res_next == '0);
`endif
            state     <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu181_slice_sequencer.sv
// Bench for alu181_slice_sequencer: 74181 slice model, W-bit reference model, directed and random ops.
// Build with +define+ALU181_ZERO_EN to also check rsp_zero.
module tb_alu181_slice_sequencer;
  localparam int SLICES = 4;
  localparam int W      = 4 * SLICES;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [W-1:0]   req_a = '0;
  logic [W-1:0]   req_b = '0;
  logic [3:0]     req_s = 4'd0;
  logic           req_m = 1'b0;
  logic           req_cnb = 1'b1;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [W-1:0]   rsp_f;
  logic           rsp_cn4b;
  logic           rsp_aeb;
`ifdef ALU181_ZERO_EN
  logic           rsp_zero;
`endif
  logic [3:0]     alu_a, alu_b, alu_s;
  logic           alu_m, alu_cnb;
  logic [3:0]     alu_f;
  logic           alu_cn4b, alu_aeb;
  logic [1:0]     dbg_state;

  alu181_slice_sequencer #(.SLICES(SLICES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m), .req_cnb(req_cnb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_f(rsp_f), .rsp_cn4b(rsp_cn4b), .rsp_aeb(rsp_aeb),
`ifdef ALU181_ZERO_EN
    .rsp_zero(rsp_zero),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cnb(alu_cnb),
    .alu_f(alu_f), .alu_cn4b(alu_cn4b), .alu_aeb(alu_aeb),
    .dbg_state(dbg_state)
  );

  // ---------------- external 74181 slice (active-high data) ----------------
  logic [3:0] x4, y4;
  logic [4:0] sum5;
  always_comb begin
    x4       = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
    y4       = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
    sum5     = {1'b0, x4} + {1'b0, y4} + {4'b0, ~alu_cnb};
    alu_f    = alu_m ? ~(x4 ^ y4) : sum5[3:0];
    alu_cn4b = ~sum5[4];
    alu_aeb  = &alu_f;
  end

  // ---------------- W-bit reference model ----------------
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   s;
    logic         m;
    logic         cnb;
  } req_t;

  typedef struct packed {
    logic [W-1:0] f;
    logic         cn4b;
    logic         aeb;
    logic         zero;
  } rsp_t;

  function automatic logic [W-1:0] fx(input req_t r);
    return r.a | (r.b & {W{r.s[0]}}) | (~r.b & {W{r.s[1]}});
  endfunction

  function automatic logic [W-1:0] fy(input req_t r);
    return (r.a & ~r.b & {W{r.s[2]}}) | (r.a & r.b & {W{r.s[3]}});
  endfunction

  // The whole operation as one W-bit 74181: F = X + Y + carry, or ~(X ^ Y) in logic mode.
  function automatic rsp_t ref_op(input req_t r);
    logic [W:0] sum;
    logic       c;
    rsp_t       o;
    c      = ~r.cnb;
    sum    = {1'b0, fx(r)} + {1'b0, fy(r)} + c;
    o.f    = r.m ? ~(fx(r) ^ fy(r)) : sum[W-1:0];
    o.cn4b = ~sum[W];
    o.aeb  = &o.f;
    o.zero = (o.f == '0);
    return o;
  endfunction

  // Active-low carry entering bit 4*j of the W-bit addition.
  function automatic logic cnb_into(input req_t r, input int j);
    logic [W:0] mask, sum, t;
    logic       c;
    c    = ~r.cnb;
    mask = ((W+1)'(1) << (4 * j)) - 1;
    sum  = ({1'b0, fx(r)} & mask) + ({1'b0, fy(r)} & mask) + c;
    t    = sum >> (4 * j);
    return ~t[0];
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int n_done = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [W-1:0] exp_q[$];
  logic [3:0]   cap_a[$];
  logic         cap_cnb[$];

  bit           busy = 1'b0;
  int           age  = 0;
  req_t         cur;
  rsp_t         cur_rsp;
  logic         e_req_ready = 1'b1;
  logic         e_rsp_valid = 1'b0;
  logic [W-1:0] e_f = '0;
  logic         e_cn4b = 1'b1;
  logic         e_aeb = 1'b0;
  logic         e_zero = 1'b0;

  // Compare on the falling edge, then predict what the coming rising edge will do.
  always @(negedge clk) begin
    logic [W-1:0] sh;
    if (!rst_n) begin
      busy = 1'b0; age = 0; exp_q.delete();
      e_req_ready = 1'b1; e_rsp_valid = 1'b0;
      e_f = '0; e_cn4b = 1'b1; e_aeb = 1'b0; e_zero = 1'b0;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_f", rsp_f, '0);
      chk("rst_rsp_cn4b", rsp_cn4b, 1'b1);
      chk("rst_rsp_aeb", rsp_aeb, 1'b0);
      chk("rst_alu_a", alu_a, 4'd0);
      chk("rst_alu_b", alu_b, 4'd0);
      chk("rst_alu_s", alu_s, 4'd0);
      chk("rst_alu_m", alu_m, 1'b0);
      chk("rst_alu_cnb", alu_cnb, 1'b1);
`ifdef ALU181_ZERO_EN
      chk("rst_rsp_zero", rsp_zero, 1'b0);
`endif
    end else begin
      chk("req_ready", req_ready, e_req_ready);
      chk("rsp_valid", rsp_valid, e_rsp_valid);
      if (e_rsp_valid) begin
        chk("rsp_f", rsp_f, e_f);
        chk("rsp_cn4b", rsp_cn4b, e_cn4b);
        chk("rsp_aeb", rsp_aeb, e_aeb);
`ifdef ALU181_ZERO_EN
        chk("rsp_zero", rsp_zero, e_zero);
`endif
      end else if (!busy) begin
        chk("rsp_f_hold", rsp_f, e_f);
      end
      if (busy && age >= 1 && age <= SLICES) begin
        sh = cur.a >> (4 * (age - 1));
        chk("alu_a", alu_a, sh[3:0]);
        sh = cur.b >> (4 * (age - 1));
        chk("alu_b", alu_b, sh[3:0]);
        chk("alu_s", alu_s, cur.s);
        chk("alu_m", alu_m, cur.m);
        chk("alu_cnb", alu_cnb, cnb_into(cur, age - 1));
        cap_a.push_back(alu_a);
        cap_cnb.push_back(alu_cnb);
      end
      if (!busy) begin
        if (req_valid) begin
          cur.a = req_a; cur.b = req_b; cur.s = req_s; cur.m = req_m; cur.cnb = req_cnb;
          busy = 1'b1; age = 1; e_req_ready = 1'b0;
          exp_q.push_back(ref_op(cur).f);
        end
      end else if (age < SLICES) begin
        age++;
      end else if (age == SLICES) begin
        age++;
        cur_rsp     = ref_op(cur);
        e_rsp_valid = 1'b1;
        e_f         = exp_q[0];
        e_cn4b      = cur_rsp.cn4b;
        e_aeb       = cur_rsp.aeb;
        e_zero      = cur_rsp.zero;
      end else if (rsp_ready) begin
        busy = 1'b0; e_rsp_valid = 1'b0; e_req_ready = 1'b1;
        void'(exp_q.pop_front());
        n_done++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1 with the sequencer idle and rsp_ready high; checks literal results.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                    input logic m, input logic cnb, input logic [W-1:0] ef, input logic ecn,
                    input logic eaeb, input logic ez, input bit seq_on,
                    input logic [15:0] ea_seq, input logic [3:0] ecnb_seq, input string nm);
    int n;
    logic [15:0] pa;
    logic [3:0]  pc;
    cap_a.delete(); cap_cnb.delete();
    req_a = a; req_b = b; req_s = s; req_m = m; req_cnb = cnb; req_valid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (req_ready && n < 20);
    req_valid = 1'b0;
    chk({nm, "_accept_edges"}, n, 1);
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({nm, "_latency"}, n + 1, SLICES + 1);
    chk({nm, "_f"}, rsp_f, ef);
    chk({nm, "_cn4b"}, rsp_cn4b, ecn);
    chk({nm, "_aeb"}, rsp_aeb, eaeb);
`ifdef ALU181_ZERO_EN
    chk({nm, "_zero"}, rsp_zero, ez);
`endif
    if (seq_on) begin
      pa = '0; pc = '0;
      foreach (cap_a[i]) pa = pa | (16'(cap_a[i]) << (4 * i));
      foreach (cap_cnb[i]) pc = pc | (4'(cap_cnb[i]) << i);
      chk({nm, "_alu_a_seq"}, pa, ea_seq);
      chk({nm, "_alu_cnb_seq"}, pc, ecnb_seq);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(input string nm);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({nm, "_rsp_seen"}, rsp_valid, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    op(16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b1, 16'h2201, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 4'b0001, "add");
    op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 4'b0001, "wrap");
    op(16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, "eq");
    op(16'h5A5A, 16'h5A5B, 4'b0110, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, "neq");
    op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 16'h0FF0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, "xor");

    // Backpressure with a second request waiting and operands changing mid-operation.
    rsp_ready = 1'b0;
    req_a = 16'h1111; req_b = 16'h2222; req_s = 4'b1001; req_m = 1'b0; req_cnb = 1'b1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_a = 16'h0003; req_b = 16'h0004;
    wait_rsp("bp");
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_f", rsp_f, 16'h3333);
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_req_ready", req_ready, 1'b0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_req_ready", req_ready, 1'b1);
    chk("bp_idle_rsp_valid", rsp_valid, 1'b0);
    chk("bp_idle_f_kept", rsp_f, 16'h3333);
    @(posedge clk); #1;
    chk("bp_second_accept", req_ready, 1'b0);
    req_valid = 1'b0;
    wait_rsp("bp2");
    chk("bp2_f", rsp_f, 16'h0007);
    @(posedge clk); #1;

    // Reset in the middle of an operation, after slice edge 2.
    req_a = 16'h1234; req_b = 16'h4321; req_s = 4'b1001; req_m = 1'b0; req_cnb = 1'b1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 1'b1);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_rsp_f", rsp_f, '0);
    chk("mid_rst_alu_a", alu_a, 4'd0);
    chk("mid_rst_alu_cnb", alu_cnb, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    op(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, "post_rst");

    // Randomized traffic, the negedge model checks every cycle.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_a     = W'($urandom);
      req_b     = ($urandom_range(0, 7) == 0) ? req_a : W'($urandom);
      req_s     = 4'($urandom_range(0, 15));
      req_m     = 1'($urandom_range(0, 1));
      req_cnb   = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 40 && busy; n++) begin
      @(posedge clk); #1;
    end
    chk("drain_idle", busy, 1'b0);
    chk("rand_progress", (n_done > 150), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu181_slice_sequencer.md
Name: alu181_slice_sequencer

Overview:
- Multi-cycle initiator for a single external 4-bit 74181-type ALU slice. It sits between a request/response client and the ALU's S/M/CNb/A/B pins.
- Accepts W-bit operands plus function select, presents one nibble per cycle to the ALU (LSB nibble first), and ripples CN4b into the next CNb.
- Assembles the W-bit result and reports the final carry and a global A=B flag.
- Lets one combinational 74181 slice serve as a W-bit ALU.

Parameters:
- SLICES, 4, number of nibbles per operation; W = 4*SLICES; SLICES >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  W  operand A.
- req_b  in  W  operand B.
- req_s  in  4  74181 function select.
- req_m  in  1  mode: 1 = logic, 0 = arithmetic.
- req_cnb  in  1  carry-in, active-low, applied to slice 0.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  client accepts result.
- rsp_f  out  W  assembled result.
- rsp_cn4b  out  1  carry-out of last slice, active-low.
- rsp_aeb  out  1  AND of every slice's AEB.
- alu_a  out  4  nibble of A to ALU.
- alu_b  out  4  nibble of B to ALU.
- alu_s  out  4  to ALU S.
- alu_m  out  1  to ALU M.
- alu_cnb  out  1  to ALU CNb.
- alu_f  in  4  ALU F, combinational from alu_* in the same cycle.
- alu_cn4b  in  1  ALU CN4b.
- alu_aeb  in  1  ALU AEB.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; slice index k = 0.
  - req_ready = 1; rsp_valid = 0; rsp_f = 0; rsp_cn4b = 1; rsp_aeb = 0.
  - alu_a/alu_b/alu_s = 0; alu_m = 0; alu_cnb = 1.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid=1: latch req_a, req_b, req_s, req_m, req_cnb.
  - Then set carry register = req_cnb, aeb accumulator = 1, k = 0, and go to RUN.
- RUN:
  - req_ready = 0.
  - alu_a = A[4k+3:4k], alu_b = B[4k+3:4k]; alu_s/alu_m come from the latched request.
  - alu_cnb = carry register; all alu_* outputs are registered or driven from registered state.
  - Each edge: result[4k+3:4k] <= alu_f; carry <= alu_cn4b; aeb <= aeb & alu_aeb; k <= k+1.
  - When k = SLICES-1 at that edge, go to DONE.
- DONE:
  - rsp_valid = 1; rsp_f/rsp_cn4b/rsp_aeb hold their final values, stable until handshake.
  - Leave for IDLE on an edge with rsp_ready=1; rsp_valid drops the following cycle.
  - rsp_f keeps its last value after leaving DONE.
- Latency: accept edge E0; slice edges E1..E_SLICES; rsp_valid high after E_SLICES. That is SLICES+1 cycles from accept to rsp_valid.
- Throughput: one operation per SLICES+2 cycles with rsp_ready held high.
- Logic mode (M=1): carry is still chained and reported; F is unaffected by it, per 74181 behaviour.
- No request is accepted in RUN or DONE. req_valid may stay high and is sampled again in IDLE.
- Input changes during RUN are ignored, because operands are latched.
- Reset asserted mid-RUN or in DONE: abort immediately to reset values; no partial response.
- SLICES=1: RUN lasts one cycle.

Optional Feature:
- Macro: ALU181_ZERO_EN.
- Defined:
  - Adds output rsp_zero (1 bit), registered and valid with rsp_valid.
  - rsp_zero = 1 iff the assembled rsp_f == 0; reset value 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Add without carry: SLICES=4, S=1001, M=0, CNb=1, A=0x1234, B=0x0FCD, bench uses a 74181 model. Expect alu_a sequence 4,3,2,1 on consecutive RUN cycles; rsp_f=0x2201, rsp_cn4b=1; rsp_valid 5 cycles after accept.
- Carry ripple wrap: S=1001, M=0, CNb=1, A=0xFFFF, B=0x0001 -> alu_cnb sequence 1,0,0,0; rsp_f=0x0000, rsp_cn4b=0; with ALU181_ZERO_EN, rsp_zero=1.
- Equality: S=0110, M=0, CNb=1, A=B=0x5A5A -> rsp_f=0xFFFF, rsp_aeb=1. Repeat with B=0x5A5B -> rsp_aeb=0.
- Logic XOR: S=0110, M=1, A=0xF0F0, B=0xFF00 -> rsp_f=0x0FF0.
- Backpressure: hold rsp_ready=0 for 3 cycles in DONE, with req_valid held high and new operands applied.
  - Expect rsp_* stable and req_ready=0 throughout.
  - After rsp_ready=1, IDLE for one cycle, then the new request is accepted.
- Reset mid-operation: assert rst_n=0 asynchronously after slice edge 2 -> all outputs at reset values immediately. After release, a fresh 0x0001+0x0001 add gives rsp_f=0x0002.
